// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Single-outstanding load/store responder backed by a
//               little-endian doubleword memory with fixed response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_idx_w    = $clog2(DEPTH);
    localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic        r_err;
    logic [63:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_op_we;
    logic        w_op_uns;
    logic [1:0]  w_op_size;
    logic [63:0] w_op_addr;
    logic [63:0] w_op_wdata;
    logic [c_idx_w-1:0] w_idx;
    logic        w_oor;
    logic        w_mis;
    logic        w_bad;
    logic [63:0] w_word;
    logic [63:0] w_rd_sh;
    logic [63:0] w_load_ext;
    logic [7:0]  w_size_mask;
    logic [7:0]  w_bmask;
    logic [63:0] w_wd_sh;
    logic [63:0] w_merged;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = reset;
                if (req_valid) w_state_next = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: if (r_cnt == 4'd1) w_state_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept     = (r_state == IDLE) && req_valid;
    assign w_enter_resp = (w_state_next == RESP) && (r_state != RESP);

    // With LATENCY=1 the commit happens on the acceptance edge, so use live inputs.
    assign w_op_we    = (r_state == IDLE) ? req_we       : r_we;
    assign w_op_uns   = (r_state == IDLE) ? req_unsigned : r_uns;
    assign w_op_size  = (r_state == IDLE) ? req_size     : r_size;
    assign w_op_addr  = (r_state == IDLE) ? req_addr     : r_addr;
    assign w_op_wdata = (r_state == IDLE) ? req_wdata    : r_wdata;

    assign w_idx  = w_op_addr[3 +: c_idx_w];
    assign w_oor  = |w_op_addr[63:3+c_idx_w];
    assign w_bad  = w_oor || w_mis;
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_mis       = 1'b0;
        w_size_mask = 8'h01;
        case (w_op_size)
            2'd0: begin w_mis = 1'b0;                 w_size_mask = 8'h01; end
            2'd1: begin w_mis = w_op_addr[0];         w_size_mask = 8'h03; end
            2'd2: begin w_mis = |w_op_addr[1:0];      w_size_mask = 8'h0F; end
            default: begin w_mis = |w_op_addr[2:0];   w_size_mask = 8'hFF; end
        endcase
    end

    assign w_rd_sh = w_word >> {w_op_addr[2:0], 3'b000};

    always_comb begin
        w_load_ext = w_rd_sh;
        case (w_op_size)
            2'd0: w_load_ext = w_op_uns ? {56'd0, w_rd_sh[7:0]}
                                        : {{56{w_rd_sh[7]}}, w_rd_sh[7:0]};
            2'd1: w_load_ext = w_op_uns ? {48'd0, w_rd_sh[15:0]}
                                        : {{48{w_rd_sh[15]}}, w_rd_sh[15:0]};
            2'd2: w_load_ext = w_op_uns ? {32'd0, w_rd_sh[31:0]}
                                        : {{32{w_rd_sh[31]}}, w_rd_sh[31:0]};
            default: w_load_ext = w_rd_sh;
        endcase
    end

    assign w_bmask = w_size_mask << w_op_addr[2:0];
    assign w_wd_sh = w_op_wdata << {w_op_addr[2:0], 3'b000};

    always_comb begin
        w_merged = w_word;
        for (int b = 0; b < 8; b++) begin
            if (w_bmask[b]) w_merged[8*b +: 8] = w_wd_sh[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 64'd0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_uns   <= req_unsigned;
                r_size  <= req_size;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= c_cnt_init;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_enter_resp) begin
                r_err   <= w_bad;
                r_rdata <= (!w_op_we && !w_bad) ? w_load_ext : 64'd0;
                if (w_op_we && !w_bad) r_mem[w_idx] <= w_merged;
            end else if (r_state == RESP && rsp_ready) begin
                r_rdata <= 64'd0;
                r_err   <= 1'b0;
            end
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench for data_mem_responder
//               (LATENCY=2 main instance, LATENCY=1 throughput instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
    logic [63:0] b_req_addr, b_req_wdata;
    logic [1:0]  b_req_size;
    logic        b_rsp_valid, b_rsp_err;
    logic [63:0] b_rsp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.LATENCY(2), .DEPTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.LATENCY(1), .DEPTH(32)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
        .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(1'b1),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on the LATENCY=2 instance; hold>0 stalls rsp_ready.
    task automatic xact(input string tag, input logic we, input logic [63:0] addr,
                        input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                        input logic [63:0] exp_rdata, input logic exp_err, input int hold);
        int lat;
        bit ok;
        @(negedge clk);
        rsp_ready    = (hold == 0);
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            else @(negedge clk);
        end
        check({tag, " accept"}, 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 64'h0;
        req_wdata = '1;
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) ok = 1'b1;
        end
        check({tag, " latency"}, 64'(lat), 64'd2);
        check({tag, " rdata"}, rsp_rdata, exp_rdata);
        check({tag, " err"}, 64'(rsp_err), 64'(exp_err));
        if (hold > 0) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = addr;
            req_size  = 2'd3;
            req_wdata = 64'h0;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check({tag, " stall valid"}, 64'(rsp_valid), 64'd1);
                check({tag, " stall rdata"}, rsp_rdata, exp_rdata);
                check({tag, " stall ready"}, 64'(req_ready), 64'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, " valid drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 64'h0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 64'h0; rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 64'h0; b_req_size = 2'd0;
        b_req_unsigned = 1'b0; b_req_wdata = 64'h0;

        #12;
        check("reset ready", 64'(req_ready), 64'd0);
        check("reset valid", 64'(rsp_valid), 64'd0);
        check("reset rdata", rsp_rdata, 64'd0);
        check("reset err",   64'(rsp_err), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post-reset ready", 64'(req_ready), 64'd1);

        xact("sd 0x10",  1'b1, 64'h10, 2'd3, 1'b0, 64'h1122334455667788, 64'h0, 1'b0, 0);
        xact("ld 0x10",  1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 64'h1122334455667788, 1'b0, 0);
        xact("sb 0x21",  1'b1, 64'h21, 2'd0, 1'b0, 64'hFFFFFFFFFFFFFF80, 64'h0, 1'b0, 0);
        xact("lb 0x21",  1'b0, 64'h21, 2'd0, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0, 0);
        xact("lbu 0x21", 1'b0, 64'h21, 2'd0, 1'b1, 64'h0, 64'h0000000000000080, 1'b0, 0);
        xact("ld 0x20",  1'b0, 64'h20, 2'd3, 1'b0, 64'h0, 64'h0000000000008000, 1'b0, 0);
        xact("sh 0x22",  1'b1, 64'h22, 2'd1, 1'b0, 64'h000000001234BEEF, 64'h0, 1'b0, 0);
        xact("lh 0x22",  1'b0, 64'h22, 2'd1, 1'b0, 64'h0, 64'hFFFFFFFFFFFFBEEF, 1'b0, 0);
        xact("lhu 0x22", 1'b0, 64'h22, 2'd1, 1'b1, 64'h0, 64'h000000000000BEEF, 1'b0, 0);
        xact("ld 0x20b", 1'b0, 64'h20, 2'd3, 1'b0, 64'h0, 64'h00000000BEEF8000, 1'b0, 0);
        xact("sw 0x14",  1'b1, 64'h14, 2'd2, 1'b0, 64'h0000000080000000, 64'h0, 1'b0, 0);
        xact("lw 0x14",  1'b0, 64'h14, 2'd2, 1'b0, 64'h0, 64'hFFFFFFFF80000000, 1'b0, 0);
        xact("lwu 0x14", 1'b0, 64'h14, 2'd2, 1'b1, 64'h0, 64'h0000000080000000, 1'b0, 0);
        xact("ldu 0x10", 1'b0, 64'h10, 2'd3, 1'b1, 64'h0, 64'h8000000055667788, 1'b0, 0);
        xact("lw 0x06",  1'b0, 64'h06, 2'd2, 1'b0, 64'h0, 64'h0, 1'b1, 0);
        xact("lh 0x23",  1'b0, 64'h23, 2'd1, 1'b0, 64'h0, 64'h0, 1'b1, 0);
        xact("sd 0x100", 1'b1, 64'h100, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 0);
        xact("ld 0xF8",  1'b0, 64'hF8, 2'd3, 1'b0, 64'h0, 64'h0, 1'b0, 0);
        xact("ld 0x00",  1'b0, 64'h00, 2'd3, 1'b0, 64'h0, 64'h0, 1'b0, 0);
        xact("sh 0x21",  1'b1, 64'h21, 2'd1, 1'b0, 64'hFFFF, 64'h0, 1'b1, 0);
        xact("ld 0x20c", 1'b0, 64'h20, 2'd3, 1'b0, 64'h0, 64'h00000000BEEF8000, 1'b0, 0);
        xact("bp ld",    1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 64'h8000000055667788, 1'b0, 5);
        xact("ld after bp", 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 64'h8000000055667788, 1'b0, 0);

        // Abort a store while it is waiting out its latency.
        @(negedge clk);
        req_we = 1'b1; req_addr = 64'h30; req_size = 2'd3; req_wdata = 64'hDEAD;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("abort in wait", 64'(req_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("abort valid", 64'(rsp_valid), 64'd0);
        check("abort ready", 64'(req_ready), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort no rsp", 64'(rsp_valid), 64'd0);
        end
        xact("ld 0x30",  1'b0, 64'h30, 2'd3, 1'b0, 64'h0, 64'h0, 1'b0, 0);
        xact("ld 0x10 cleared", 1'b0, 64'h10, 2'd3, 1'b0, 64'h0, 64'h0, 1'b0, 0);

        // LATENCY=1 instance: store then continuous loads with rsp_ready tied high.
        @(negedge clk);
        b_req_we = 1'b1; b_req_addr = 64'h8; b_req_size = 2'd3;
        b_req_wdata = 64'hA5A50F0F12345678; b_req_valid = 1'b1;
        check("L1 ready", 64'(b_req_ready), 64'd1);
        @(negedge clk);
        check("L1 sd valid", 64'(b_rsp_valid), 64'd1);
        check("L1 sd err",   64'(b_rsp_err), 64'd0);
        check("L1 sd rdata", b_rsp_rdata, 64'd0);
        check("L1 busy",     64'(b_req_ready), 64'd0);
        b_req_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("L1 idle valid", 64'(b_rsp_valid), 64'd0);
            check("L1 idle ready", 64'(b_req_ready), 64'd1);
            @(negedge clk);
            check("L1 ld valid", 64'(b_rsp_valid), 64'd1);
            check("L1 ld rdata", b_rsp_rdata, 64'hA5A50F0F12345678);
        end
        b_req_valid = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, means cycles from request acceptance edge to rsp_valid high; legal range 1..15.
REQ-002 Parameter DEPTH, default 32, means number of 64-bit doublewords stored; power of two, 256 bytes at default.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port req_valid, input, 1 bit: the CPU presents a load/store request.
REQ-006 Port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 Port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 Port req_addr, input, 64 bits: byte address.
REQ-009 Port req_size, input, 2 bits: 0 = byte, 1 = half, 2 = word, 3 = doubleword.
REQ-010 Port req_unsigned, input, 1 bit: 1 = zero-extend load data (lbu/lhu/lwu), 0 = sign-extend.
REQ-011 Port req_wdata, input, 64 bits: store data, taken from the low (8<<req_size) bits.
REQ-012 Port rsp_valid, output, 1 bit: a response is pending.
REQ-013 Port rsp_ready, input, 1 bit: the CPU accepts the response.
REQ-014 Port rsp_rdata, output, 64 bits: extended load data; 0 for stores and errors.
REQ-015 Port rsp_err, output, 1 bit: the request was misaligned or out of range.

Function
REQ-016 The block SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-017 IDLE SHALL drive req_ready=1; WAIT and RESP SHALL drive req_ready=0, so at most one request is in flight.
REQ-018 On a rising edge with req_valid=1 in IDLE, the block SHALL capture we/addr/size/unsigned/wdata and load a counter with LATENCY-1.
- Next state is RESP if LATENCY=1, otherwise WAIT.
REQ-019 WAIT SHALL decrement the counter each cycle and move to RESP on the edge where the counter equals 1.
- rsp_valid therefore rises exactly LATENCY cycles after the acceptance edge.
REQ-020 On the edge entering RESP, a valid store SHALL update only the addressed bytes (little-endian); a load SHALL register its read data.
REQ-021 In RESP, rsp_valid=1, rsp_rdata and rsp_err SHALL stay stable until an edge with rsp_ready=1.
- That edge returns the block to IDLE; rsp_valid=0 the following cycle.
REQ-022 A new request SHALL be accepted no sooner than the edge after the response handshake.
- Back-to-back throughput is one request per LATENCY+1 cycles.
REQ-023 A request SHALL be misaligned when req_addr[size-1:0] != 0 (byte accesses never misalign).
REQ-024 A request SHALL be out of range when req_addr >= 8*DEPTH.
REQ-025 For a misaligned or out-of-range request: rsp_err=1, rsp_rdata=0, and memory SHALL be unchanged.
REQ-026 A load SHALL return the addressed bytes right-justified, sign- or zero-extended to 64 bits per req_unsigned.
- req_unsigned SHALL be ignored for size 3.
REQ-027 A store response SHALL carry rsp_rdata=0 and rsp_err=0 when legal.
REQ-028 Changes on req_* inputs outside IDLE SHALL have no effect.
REQ-029 The block SHALL never drop or duplicate a response, whatever rsp_ready does.

Reset
REQ-030 While reset=0, regardless of clk: state=IDLE, req_ready=1 (once reset releases), rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, all memory words=0.
- Before release, req_ready SHALL read 0.
REQ-031 Reset asserted mid-transaction SHALL abort it.
- A store not yet committed SHALL NOT be written.
- No response SHALL appear after release.
REQ-032 The first request SHALL be accepted on the first rising edge after reset=1 at which req_valid=1.

Verification
REQ-033 Store-then-load doubleword: sd 0x1122334455667788 at addr 0x10, then ld 0x10.
- Required: rsp_rdata=0x1122334455667788, rsp_err=0, rsp_valid high exactly 2 cycles after each acceptance.
REQ-034 Sub-word extension: sb 0x80 at addr 0x21.
- lb 0x21 -> 0xFFFFFFFFFFFFFF80.
- lbu 0x21 -> 0x0000000000000080.
- ld 0x20 -> 0x0000000000008000.
REQ-035 Errors:
- lw at 0x06 -> rsp_err=1, rsp_rdata=0.
- sd at 0x100 -> rsp_err=1; a later ld 0xF8 is unchanged.
REQ-036 Backpressure: hold rsp_ready=0 for 5 cycles on a load of 0x10.
- Required: rsp_valid and rsp_rdata stable for 5 cycles, req_ready=0 throughout, one handshake.
REQ-037 Reset abort: pull reset low in WAIT of sd 0xDEAD at 0x30.
- Required: rsp_valid never rises; ld 0x30 after release -> 0.
REQ-038 LATENCY=1 build: back-to-back loads with rsp_ready=1 tied.
- Required: rsp_valid in the cycle after each acceptance; one request every 2 cycles.
